// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state type, reset PC and
// ibus field widths, plus the sequential-PC helper used for out_next_pc.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_WAIT,
        F_DONE
    } fetch_state_t;

    localparam int unsigned IBUS_ADDR_W = 32;
    localparam int unsigned IBUS_DATA_W = 32;

    localparam logic [IBUS_ADDR_W-1:0] RESET_PC_DEFAULT = 32'hbfc0_0000;

    // PC that follows the fetched instruction; wraps modulo 2^32.
    function automatic logic [IBUS_ADDR_W-1:0] calc_next_pc(
        input logic                   delayed,
        input logic [IBUS_ADDR_W-1:0] delayed_pc,
        input logic [IBUS_ADDR_W-1:0] pc
    );
        return delayed ? delayed_pc : pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_reuse_buf.sv
// One-entry instruction reuse buffer {valid, pc, instr}: lookup, fill and flush.
// Only instantiated by fetch_unit when FETCH_REUSE_EN is defined.
module fetch_reuse_buf
    import fetch_unit_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_flush,
    input  logic                   i_fill,
    input  logic [IBUS_ADDR_W-1:0] i_fill_pc,
    input  logic [IBUS_DATA_W-1:0] i_fill_instr,
    input  logic [IBUS_ADDR_W-1:0] i_lookup_pc,
    output logic                   o_hit,
    output logic [IBUS_DATA_W-1:0] o_instr
);

    logic                   r_valid;
    logic [IBUS_ADDR_W-1:0] r_pc;
    logic [IBUS_DATA_W-1:0] r_instr;

    // Tag/data storage; a flush in the same cycle as a fill leaves the entry invalid.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_instr <= '0;
        end else begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (i_fill) begin
                r_valid <= 1'b1;
            end
            if (i_fill) begin
                r_pc    <= i_fill_pc;
                r_instr <= i_fill_instr;
            end
        end
    end

    // A flush presented alongside a lookup suppresses the hit.
    always_comb begin
        o_hit   = r_valid && !i_flush && (r_pc == i_lookup_pc);
        o_instr = r_instr;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues one ibus read per start pulse, returns the word, its PC,
// the following PC (branch delay slot aware) and an AdEL fault for misaligned PCs.
// Optional feature macro: FETCH_REUSE_EN (one-entry reuse buffer, skips the bus on a hit).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [IBUS_ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [IBUS_ADDR_W-1:0] i_pc,
    input  logic                   i_delayed,
    input  logic [IBUS_ADDR_W-1:0] i_delayed_pc,
    input  logic                   i_flush,
    output logic                   o_ireq_valid,
    output logic [IBUS_ADDR_W-1:0] o_ireq_addr,
    input  logic                   i_iresp_addr_ok,
    input  logic                   i_iresp_data_ok,
    input  logic [IBUS_DATA_W-1:0] i_iresp_data,
    output logic                   o_done,
    output logic [IBUS_ADDR_W-1:0] o_out_pc,
    output logic [IBUS_DATA_W-1:0] o_out_instr,
    output logic [IBUS_ADDR_W-1:0] o_out_next_pc,
    output logic                   o_out_in_slot,
    output logic                   o_out_fault
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [IBUS_ADDR_W-1:0] r_pc;
    logic [IBUS_ADDR_W-1:0] r_delayed_pc;
    logic                   r_delayed;

    logic [IBUS_ADDR_W-1:0] r_out_pc;
    logic [IBUS_DATA_W-1:0] r_out_instr;
    logic [IBUS_ADDR_W-1:0] r_out_next_pc;
    logic                   r_out_in_slot;
    logic                   r_out_fault;

    logic                   w_latch;
    logic                   w_capture;
    logic                   w_load;
    logic                   w_hit;
    logic [IBUS_DATA_W-1:0] w_buf_instr;

    logic [IBUS_ADDR_W-1:0] w_ld_pc;
    logic [IBUS_DATA_W-1:0] w_ld_instr;
    logic [IBUS_ADDR_W-1:0] w_ld_next_pc;
    logic                   w_ld_slot;
    logic                   w_ld_fault;

`ifdef FETCH_REUSE_EN
    fetch_reuse_buf u_reuse_buf (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_flush      (i_flush),
        .i_fill       (w_capture),
        .i_fill_pc    (r_pc),
        .i_fill_instr (i_iresp_data),
        .i_lookup_pc  (i_pc),
        .o_hit        (w_hit),
        .o_instr      (w_buf_instr)
    );
`else
    logic w_unused_flush;
    assign w_unused_flush = i_flush;
    assign w_hit          = 1'b0;
    assign w_buf_instr    = '0;
`endif

    // Next-state and output-load decode. The idle path loads straight from the inputs
    // (fault or reuse hit); the bus path loads from the latched request.
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_capture    = 1'b0;
        w_load       = 1'b0;
        w_ld_pc      = r_pc;
        w_ld_instr   = i_iresp_data;
        w_ld_next_pc = calc_next_pc(r_delayed, r_delayed_pc, r_pc);
        w_ld_slot    = r_delayed;
        w_ld_fault   = 1'b0;
        case (r_state)
            F_IDLE: begin
                if (i_start) begin
                    w_latch      = 1'b1;
                    w_ld_pc      = i_pc;
                    w_ld_next_pc = calc_next_pc(i_delayed, i_delayed_pc, i_pc);
                    w_ld_slot    = i_delayed;
                    if (i_pc[1:0] != 2'b00) begin
                        w_state_next = F_DONE;
                        w_load       = 1'b1;
                        w_ld_fault   = 1'b1;
                        w_ld_instr   = '0;
                    end else if (w_hit) begin
                        w_state_next = F_DONE;
                        w_load       = 1'b1;
                        w_ld_instr   = w_buf_instr;
                    end else begin
                        w_state_next = F_REQ;
                    end
                end
            end
            F_REQ: begin
                if (i_iresp_addr_ok) begin
                    if (i_iresp_data_ok) begin
                        w_capture    = 1'b1;
                        w_load       = 1'b1;
                        w_state_next = F_DONE;
                    end else begin
                        w_state_next = F_WAIT;
                    end
                end
            end
            F_WAIT: begin
                if (i_iresp_data_ok) begin
                    w_capture    = 1'b1;
                    w_load       = 1'b1;
                    w_state_next = F_DONE;
                end
            end
            F_DONE: begin
                w_state_next = F_IDLE;
            end
            default: begin
                w_state_next = F_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= F_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request latch: captured on an accepted start, drives ireq_addr for the whole request.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc         <= RESET_PC;
            r_delayed    <= 1'b0;
            r_delayed_pc <= '0;
        end else if (w_latch) begin
            r_pc         <= i_pc;
            r_delayed    <= i_delayed;
            r_delayed_pc <= i_delayed_pc;
        end
    end

    // Result registers: loaded on entry to F_DONE and held until the next completion.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_out_pc      <= RESET_PC;
            r_out_instr   <= '0;
            r_out_next_pc <= RESET_PC + 32'd4;
            r_out_in_slot <= 1'b0;
            r_out_fault   <= 1'b0;
        end else if (w_load) begin
            r_out_pc      <= w_ld_pc;
            r_out_instr   <= w_ld_instr;
            r_out_next_pc <= w_ld_next_pc;
            r_out_in_slot <= w_ld_slot;
            r_out_fault   <= w_ld_fault;
        end
    end

    // Outputs; the request is masked during reset so it drops in the reset cycle itself.
    always_comb begin
        o_ireq_valid  = (r_state == F_REQ) && !i_reset;
        o_ireq_addr   = r_pc;
        o_done        = (r_state == F_DONE);
        o_out_pc      = r_out_pc;
        o_out_instr   = r_out_instr;
        o_out_next_pc = r_out_next_pc;
        o_out_in_slot = r_out_in_slot;
        o_out_fault   = r_out_fault;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a transaction-level model schedules, per cycle, what
// the DUT must show; one negedge process compares every output against it.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hbfc0_0000;
`ifdef FETCH_REUSE_EN
    localparam bit ReuseEn = 1'b1;
`else
    localparam bit ReuseEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic [31:0] i_pc = '0;
    logic        i_delayed = 1'b0;
    logic [31:0] i_delayed_pc = '0;
    logic        i_flush = 1'b0;
    logic        o_ireq_valid;
    logic [31:0] o_ireq_addr;
    logic        i_iresp_addr_ok = 1'b0;
    logic        i_iresp_data_ok = 1'b0;
    logic [31:0] i_iresp_data = '0;
    logic        o_done;
    logic [31:0] o_out_pc;
    logic [31:0] o_out_instr;
    logic [31:0] o_out_next_pc;
    logic        o_out_in_slot;
    logic        o_out_fault;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_start         (i_start),
        .i_pc            (i_pc),
        .i_delayed       (i_delayed),
        .i_delayed_pc    (i_delayed_pc),
        .i_flush         (i_flush),
        .o_ireq_valid    (o_ireq_valid),
        .o_ireq_addr     (o_ireq_addr),
        .i_iresp_addr_ok (i_iresp_addr_ok),
        .i_iresp_data_ok (i_iresp_data_ok),
        .i_iresp_data    (i_iresp_data),
        .o_done          (o_done),
        .o_out_pc        (o_out_pc),
        .o_out_instr     (o_out_instr),
        .o_out_next_pc   (o_out_next_pc),
        .o_out_in_slot   (o_out_in_slot),
        .o_out_fault     (o_out_fault)
    );

    always #5 clk = ~clk;

    // Expected per-cycle DUT view, written by the stimulus process only.
    bit          chk_en = 1'b0;
    bit          e_req = 1'b0;
    logic [31:0] e_addr = '0;
    bit          e_done = 1'b0;
    logic [31:0] e_pc = RST_PC;
    logic [31:0] e_instr = '0;
    logic [31:0] e_next = RST_PC + 32'd4;
    bit          e_slot = 1'b0;
    bit          e_fault = 1'b0;

    // Reuse-buffer model (only consulted when the feature is built in).
    bit          m_valid = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_instr = '0;

    // Hand-computed literal pins, checked at the next negedge.
    int          pin_req = 0;
    int          pin_seen = 0;
    logic [31:0] pin_pc, pin_instr, pin_next;
    bit          pin_slot, pin_fault;

    int total = 0;
    int bad = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("ireq_valid", {31'b0, o_ireq_valid}, {31'b0, e_req});
            if (e_req) cmp("ireq_addr", o_ireq_addr, e_addr);
            cmp("done", {31'b0, o_done}, {31'b0, e_done});
            cmp("out_pc", o_out_pc, e_pc);
            cmp("out_instr", o_out_instr, e_instr);
            cmp("out_next_pc", o_out_next_pc, e_next);
            cmp("out_in_slot", {31'b0, o_out_in_slot}, {31'b0, e_slot});
            cmp("out_fault", {31'b0, o_out_fault}, {31'b0, e_fault});
            if (pin_req != pin_seen) begin
                cmp("pin_pc", o_out_pc, pin_pc);
                cmp("pin_instr", o_out_instr, pin_instr);
                cmp("pin_next_pc", o_out_next_pc, pin_next);
                cmp("pin_slot", {31'b0, o_out_in_slot}, {31'b0, pin_slot});
                cmp("pin_fault", {31'b0, o_out_fault}, {31'b0, pin_fault});
                pin_seen = pin_req;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pin(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] nxt,
                       input bit slot, input bit fault);
        pin_pc    = pc;
        pin_instr = instr;
        pin_next  = nxt;
        pin_slot  = slot;
        pin_fault = fault;
        pin_req++;
    endtask

    task automatic set_result(input logic [31:0] pc, input logic [31:0] instr, input bit dl,
                              input logic [31:0] dpc, input bit fault);
        e_pc    = pc;
        e_instr = instr;
        e_next  = dl ? dpc : pc + 32'd4;
        e_slot  = dl;
        e_fault = fault;
    endtask

    // One fetch starting in the current cycle. aw: cycles addr_ok is withheld; dw: cycles
    // from addr_ok to data_ok (0 = same cycle). noise: start pulses while busy.
    task automatic fetch(input logic [31:0] pc, input bit dl, input logic [31:0] dpc,
                         input int aw, input int dw, input logic [31:0] data, input bit noise);
        bit          hit;
        bit          mis;
        logic [31:0] v;
        mis = (pc[1:0] != 2'b00);
        hit = ReuseEn && !mis && m_valid && (m_pc == pc);
        i_start = 1'b1; i_pc = pc; i_delayed = dl; i_delayed_pc = dpc;
        i_iresp_addr_ok = 1'b0; i_iresp_data_ok = 1'b0; i_flush = 1'b0;
        e_req = 1'b0; e_done = 1'b0;
        next_cycle();
        i_start = 1'b0;
        i_pc = $urandom; i_delayed_pc = $urandom;
        v = $urandom; i_delayed = v[0];
        if (mis || hit) begin
            e_done = 1'b1;
            set_result(pc, mis ? 32'h0 : m_instr, dl, dpc, mis);
            next_cycle();
            e_done = 1'b0;
            return;
        end
        e_req = 1'b1; e_addr = pc;
        for (int i = 0; i < aw; i++) begin
            v = $urandom; i_start = noise & v[0];
            i_iresp_data = $urandom;
            next_cycle();
        end
        i_iresp_addr_ok = 1'b1;
        if (dw == 0) begin
            i_iresp_data_ok = 1'b1; i_iresp_data = data;
        end
        next_cycle();
        i_iresp_addr_ok = 1'b0; i_iresp_data_ok = 1'b0; e_req = 1'b0;
        if (dw > 0) begin
            for (int j = 1; j < dw; j++) begin
                v = $urandom; i_start = noise & v[0];
                next_cycle();
            end
            i_iresp_data_ok = 1'b1; i_iresp_data = data;
            next_cycle();
            i_iresp_data_ok = 1'b0;
        end
        v = $urandom; i_start = noise & v[0];
        e_done = 1'b1;
        set_result(pc, data, dl, dpc, 1'b0);
        m_valid = 1'b1; m_pc = pc; m_instr = data;
        next_cycle();
        i_start = 1'b0; e_done = 1'b0;
    endtask

    // Idle gap with stray data_ok (must be ignored) and optional flush.
    task automatic idle(input int n, input bit force_flush);
        logic [31:0] v;
        for (int i = 0; i < n; i++) begin
            v = $urandom;
            i_iresp_data_ok = v[0];
            i_iresp_data    = $urandom;
            i_flush         = force_flush | (v[3:2] == 2'b00);
            if (i_flush) m_valid = 1'b0;
            next_cycle();
            i_iresp_data_ok = 1'b0;
            i_flush         = 1'b0;
        end
    endtask

    // Reset lands while the DUT waits for data; everything returns to reset values.
    task automatic reset_mid();
        i_start = 1'b1; i_pc = 32'h1234_5670; i_delayed = 1'b0; i_delayed_pc = '0;
        e_req = 1'b0; e_done = 1'b0;
        next_cycle();
        e_req = 1'b1; e_addr = 32'h1234_5670;
        i_iresp_addr_ok = 1'b1;
        next_cycle();
        i_iresp_addr_ok = 1'b0; e_req = 1'b0;
        i_start = 1'b0; i_reset = 1'b1;
        next_cycle();
        i_reset = 1'b0;
        set_result(RST_PC, 32'h0, 1'b0, 32'h0, 1'b0);
        m_valid = 1'b0;
        pin(32'hbfc0_0000, 32'h0, 32'hbfc0_0004, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] pc, last_pc, v, dpc, data;
        int aw, dw;
        bit dl;
        next_cycle();
        next_cycle();
        i_reset = 1'b0;
        chk_en  = 1'b1;
        pin(32'hbfc0_0000, 32'h0, 32'hbfc0_0004, 1'b0, 1'b0);
        idle(1, 1'b0);

        fetch(32'hbfc0_0000, 1'b0, 32'h0, 0, 3, 32'h2408_0001, 1'b0);
        pin(32'hbfc0_0000, 32'h2408_0001, 32'hbfc0_0004, 1'b0, 1'b0);
        fetch(32'h8000_0010, 1'b1, 32'h8000_0100, 1, 1, 32'h1111_2222, 1'b0);
        pin(32'h8000_0010, 32'h1111_2222, 32'h8000_0100, 1'b1, 1'b0);
        fetch(32'h8000_0002, 1'b0, 32'h0, 0, 0, 32'h0, 1'b0);
        pin(32'h8000_0002, 32'h0, 32'h8000_0006, 1'b0, 1'b1);
        fetch(32'h8000_0020, 1'b0, 32'h0, 5, 0, 32'hcafe_0004, 1'b1);
        pin(32'h8000_0020, 32'hcafe_0004, 32'h8000_0024, 1'b0, 1'b0);
        fetch(32'hffff_fffc, 1'b0, 32'h0, 2, 2, 32'h0bad_f00d, 1'b1);
        pin(32'hffff_fffc, 32'h0bad_f00d, 32'h0000_0000, 1'b0, 1'b0);
        reset_mid();
        fetch(32'h8000_0040, 1'b0, 32'h0, 1, 2, 32'h3c1d_8000, 1'b1);
        pin(32'h8000_0040, 32'h3c1d_8000, 32'h8000_0044, 1'b0, 1'b0);
`ifdef FETCH_REUSE_EN
        fetch(32'h8000_0080, 1'b0, 32'h0, 1, 1, 32'h2402_0007, 1'b0);
        fetch(32'h8000_0080, 1'b0, 32'h0, 1, 1, 32'hdead_beef, 1'b0);
        pin(32'h8000_0080, 32'h2402_0007, 32'h8000_0084, 1'b0, 1'b0);
        idle(1, 1'b1);
        fetch(32'h8000_0080, 1'b0, 32'h0, 1, 1, 32'h2402_0008, 1'b0);
        pin(32'h8000_0080, 32'h2402_0008, 32'h8000_0084, 1'b0, 1'b0);
`endif

        last_pc = 32'h8000_0040;
        for (int n = 0; n < 150; n++) begin
            v = $urandom;
            case (v[3:0])
                4'd0, 4'd1: pc = last_pc;
                4'd2:       pc = $urandom;
                4'd3:       pc = 32'hffff_fffc;
                default: begin
                    pc = $urandom;
                    pc[1:0] = 2'b00;
                end
            endcase
            dl   = v[4];
            dpc  = $urandom;
            data = $urandom;
            aw   = int'($urandom_range(0, 5));
            dw   = int'($urandom_range(0, 4));
            fetch(pc, dl, dpc, aw, dw, data, 1'b1);
            idle(int'($urandom_range(0, 2)), 1'b0);
            last_pc = pc;
        end
        idle(2, 1'b0);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
